// File: rtl/serial_reg_pkg.sv
// +----------------------------------------------------------------------------+
// | serial_reg_pkg                                                             |
// | Shared constants and FSM state type for the serial control-register bank.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package serial_reg_pkg;

    localparam int         DEFAULT_NUM_REGS = 64;

    localparam logic [6:0] ADDR_COMMIT = 7'h30;
    localparam logic [6:0] ADDR_CTRL   = 7'h32;
    localparam logic [6:0] ADDR_STATUS = 7'h33;

    typedef enum logic [0:0] {
        NOADDR = 1'b0,
        READY  = 1'b1
    } state_e;

endpackage

`default_nettype wire

// File: rtl/serial_reg_bank_regfile.sv
// +----------------------------------------------------------------------------+
// | nibble_regfile                                                             |
// | NUM_REGS x 4-bit storage: one write port, registered byte readback and a   |
// | flat view of all nibbles for operand assembly.                             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module nibble_regfile #(
    parameter int NUM_REGS = 64
) (
    input  logic                    clk,
    input  logic                    areset,
    input  logic                    we_i,
    input  logic [6:0]              waddr_i,
    input  logic [3:0]              wdata_i,
    input  logic [6:0]              raddr_i,
    input  logic                    alt_sel_i,
    input  logic [3:0]              alt_data_i,
    output logic [7:0]              rdata_o,
    output logic [4*NUM_REGS-1:0]   flat_o
);

    localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic [3:0] mem_q [NUM_REGS];
    logic [7:0] rdata_q;
    logic       rd_in_range;

    assign rd_in_range = ({1'b0, raddr_i} < 8'(NUM_REGS));

    // The alternate nibble lets the owner map a non-stored status bit into readback.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= 4'h0;
            end
            rdata_q <= 8'h00;
        end else begin
            if (we_i) begin
                mem_q[waddr_i[AW-1:0]] <= wdata_i;
            end
            if (alt_sel_i) begin
                rdata_q <= {4'h0, alt_data_i};
            end else if (rd_in_range) begin
                rdata_q <= {4'h0, mem_q[raddr_i[AW-1:0]]};
            end else begin
                rdata_q <= 8'h00;
            end
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
        assign flat_o[4*i +: 4] = mem_q[i];
    end

    assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/serial_reg_bank.sv
// +----------------------------------------------------------------------------+
// | serial_reg_bank                                                            |
// | Byte-stream driven register bank with committed operand snapshot output.   |
// | Option: define REG_AUTOINC_EN to post-increment addr after data bytes.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module serial_reg_bank
    import serial_reg_pkg::*;
#(
    parameter int NUM_REGS = DEFAULT_NUM_REGS,
    parameter int A_BASE   = 0,
    parameter int B_BASE   = 16
) (
    input  logic        clk,
    input  logic        areset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic [63:0] operand_a,
    output logic [63:0] operand_b,
    output logic        operand_valid,
    input  logic        operand_ready,
    output logic        output_on,
    output logic        overrun,
    output logic [7:0]  tx_data
);

    state_e                 state_q;
    logic [6:0]             addr_q,  addr_d;
    logic [63:0]            op_a_q,  op_a_d;
    logic [63:0]            op_b_q,  op_b_d;
    logic                   valid_q, valid_d;
    logic                   ovr_q,   ovr_d;
    logic [4*NUM_REGS-1:0]  regs_flat;

    logic is_addr, is_data, in_range, is_status, reg_we, commit_req, commit_take;

    assign is_addr     = rx_valid &  rx_data[7];
    assign is_data     = rx_valid & ~rx_data[7] & (state_q == READY);
    assign in_range    = ({1'b0, addr_q} < 8'(NUM_REGS));
    assign is_status   = (addr_q == ADDR_STATUS);
    assign reg_we      = is_data & in_range & ~is_status;
    assign commit_req  = is_data & (addr_q == ADDR_COMMIT) & rx_data[0];
    assign commit_take = commit_req & (~valid_q | operand_ready);

    always_comb begin
        addr_d  = addr_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;

        if (is_addr) begin
            addr_d = rx_data[6:0];
        end else if (is_data) begin
`ifdef REG_AUTOINC_EN
            addr_d = addr_q + 7'd1;
`else
            addr_d = addr_q;
`endif
        end

        // Snapshot uses the file before this byte's write; a load during an accept keeps valid high.
        if (commit_take) begin
            op_a_d  = regs_flat[4*A_BASE +: 64];
            op_b_d  = regs_flat[4*B_BASE +: 64];
            valid_d = 1'b1;
        end else if (valid_q & operand_ready) begin
            valid_d = 1'b0;
        end

        if (is_data & is_status) begin
            ovr_d = 1'b0;
        end else if (commit_req & ~commit_take) begin
            ovr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q <= NOADDR;
            addr_q  <= 7'h00;
            op_a_q  <= 64'h0;
            op_b_q  <= 64'h0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            case (state_q)
                NOADDR:  state_q <= is_addr ? READY : NOADDR;
                READY:   state_q <= READY;
                default: state_q <= NOADDR;
            endcase
            addr_q  <= addr_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    nibble_regfile #(
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clk        (clk),
        .areset     (areset),
        .we_i       (reg_we),
        .waddr_i    (addr_q),
        .wdata_i    (rx_data[3:0]),
        .raddr_i    (addr_q),
        .alt_sel_i  (is_status),
        .alt_data_i ({3'b000, ovr_q}),
        .rdata_o    (tx_data),
        .flat_o     (regs_flat)
    );

    assign operand_a     = op_a_q;
    assign operand_b     = op_b_q;
    assign operand_valid = valid_q;
    assign overrun       = ovr_q;
    assign output_on     = regs_flat[4*int'(ADDR_CTRL)];

endmodule

`default_nettype wire

// File: tb/tb_serial_reg_bank.sv
// +----------------------------------------------------------------------------+
// | tb_serial_reg_bank                                                         |
// | Directed and random byte streams checked against a behavioural model.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_serial_reg_bank;

    logic        clk = 1'b0;
    logic        areset = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        operand_ready = 1'b0;
    logic [63:0] operand_a, operand_b;
    logic        operand_valid, output_on, overrun;
    logic [7:0]  tx_data;

    int checks = 0;
    int failures = 0;

    serial_reg_bank dut (
        .clk           (clk),
        .areset        (areset),
        .rx_valid      (rx_valid),
        .rx_data       (rx_data),
        .operand_a     (operand_a),
        .operand_b     (operand_b),
        .operand_valid (operand_valid),
        .operand_ready (operand_ready),
        .output_on     (output_on),
        .overrun       (overrun),
        .tx_data       (tx_data)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [3:0]  m_regs [64];
    int          m_addr;
    bit          m_haveaddr;
    logic [63:0] m_a, m_b;
    bit          m_valid, m_ovr;
    logic [7:0]  m_tx;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] snap(input int base);
        logic [63:0] r = 64'h0;
        for (int i = 0; i < 16; i++) r = r | (64'(m_regs[base + i]) << (4 * i));
        return r;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 64; i++) m_regs[i] = 4'h0;
        m_addr = 0; m_haveaddr = 0; m_a = 0; m_b = 0;
        m_valid = 0; m_ovr = 0; m_tx = 8'h00;
    endtask

    task automatic check_all(input string where);
        chk({where, ".valid"},    64'(operand_valid), 64'(m_valid));
        chk({where, ".opa"},      operand_a, m_a);
        chk({where, ".opb"},      operand_b, m_b);
        chk({where, ".overrun"},  64'(overrun), 64'(m_ovr));
        chk({where, ".output_on"},64'(output_on), 64'(m_regs[8'h32][0]));
        chk({where, ".tx"},       64'(tx_data), 64'(m_tx));
    endtask

    // One clock cycle: drive, update model from the pre-edge state, compare after the edge.
    task automatic step(input bit v, input logic [7:0] d, input bit rdy, input string where);
        bit fire;
        @(negedge clk);
        rx_valid = v; rx_data = d; operand_ready = rdy;
        if (m_addr == 8'h33)   m_tx = {7'h0, m_ovr};
        else if (m_addr < 64)  m_tx = {4'h0, m_regs[m_addr]};
        else                   m_tx = 8'h00;
        fire = m_valid && rdy;
        if (v && d[7]) begin
            m_addr = int'(d[6:0]);
            m_haveaddr = 1;
            if (fire) m_valid = 0;
        end else if (v && m_haveaddr) begin
            if (m_addr == 8'h30 && d[0]) begin
                if (!m_valid || rdy) begin
                    m_a = snap(0); m_b = snap(16); m_valid = 1;
                end else begin
                    m_ovr = 1;
                end
            end else if (fire) begin
                m_valid = 0;
            end
            if (m_addr == 8'h33)  m_ovr = 0;
            else if (m_addr < 64) m_regs[m_addr] = d[3:0];
`ifdef REG_AUTOINC_EN
            m_addr = (m_addr + 1) % 128;
`endif
        end else if (fire) begin
            m_valid = 0;
        end
        @(posedge clk);
        #1;
        check_all(where);
    endtask

    initial begin
        model_clear();
        repeat (3) @(negedge clk);
        areset = 1'b0;
        #1;
        check_all("reset");

        step(1, 8'h05, 0, "noaddr_data");
        step(0, 8'h00, 0, "noaddr_idle");

        step(1, 8'h80, 0, "addr0");
        for (int i = 1; i < 16; i++) step(1, 8'(i), 0, "fill");
        step(1, 8'h00, 0, "fill15");
        step(1, 8'hB0, 0, "addr_commit");
        step(1, 8'h01, 0, "commit1");
`ifdef REG_AUTOINC_EN
        chk("plan_opa", operand_a, 64'h0FED_CBA9_8765_4321);
`endif
        chk("plan_valid", 64'(operand_valid), 64'h1);

        step(1, 8'h80, 0, "readdr0");
        step(1, 8'h0C, 0, "modify_r0");
        step(1, 8'hB0, 0, "addr_commit2");
        step(1, 8'h01, 0, "commit_overrun");
        chk("plan_overrun", 64'(overrun), 64'h1);
        step(1, 8'hB3, 0, "addr_status");
        step(0, 8'h00, 0, "status_read");
        step(1, 8'h00, 0, "status_clear");
        chk("plan_ovr_clear", 64'(overrun), 64'h0);

        step(1, 8'hB0, 0, "addr_commit3");
        step(1, 8'h01, 1, "commit_accept");
        chk("plan_reload_a0", 64'(operand_a[3:0]), 64'hC);
        step(1, 8'hB2, 0, "addr_ctrl");
        step(1, 8'h01, 0, "ctrl_on");
        chk("plan_output_on", 64'(output_on), 64'h1);
        step(1, 8'hFF, 0, "addr_7f");
        step(1, 8'h03, 0, "write_7f");
        step(0, 8'h00, 0, "wrap_read");

        @(negedge clk);
        rx_valid = 0; operand_ready = 0;
        #2 areset = 1'b1;
        #1;
        model_clear();
        check_all("async_reset");
        @(negedge clk);
        areset = 1'b0;
        step(1, 8'h07, 0, "post_reset_drop");
        step(0, 8'h00, 0, "post_reset_idle");

        for (int n = 0; n < 400; n++) begin
            bit         v   = ($urandom_range(0, 3) != 0);
            bit         rdy = ($urandom_range(0, 2) == 0);
            logic [7:0] d;
            case ($urandom_range(0, 5))
                0: d = 8'hB0;
                1: d = 8'hB3;
                2: d = {1'b1, 7'($urandom_range(0, 127))};
                3: d = {1'b1, 7'($urandom_range(0, 31))};
                default: d = {4'h0, 4'($urandom)};
            endcase
            step(v, d, rdy, "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
